// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - product stream in, frame result out, between multiplier and accumulator
interface product_accumulator_if #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      in_product;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport master (
        output in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - frame-wise sum of multiplier products; ACC_SAT_EN selects saturating over wrapping
module product_accumulator #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    product_accumulator_if.slave  bus
);
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             ready_q;
    logic             accept;
    logic [ACC_W:0]   sum_wide;
    logic             carry;

    // ready_q is low for the first cycle after reset even though state is ACCUM
    assign accept   = bus.in_valid && ready_q;
    assign sum_wide = {1'b0, acc_q} + (ACC_W+1)'(bus.in_product);
    assign carry    = sum_wide[ACC_W];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
`ifdef ACC_SAT_EN
                    acc_d = carry ? '1 : sum_wide[ACC_W-1:0];
`else
                    acc_d = sum_wide[ACC_W-1:0];
`endif
                    ovf_d = ovf_q | carry;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (bus.in_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ready_q <= (state_d == ACCUM);
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench driving a default-width and a narrow (25/2) instance in lockstep
module tb_product_accumulator;
    localparam int AW  = 32;
    localparam int CW  = 8;
    localparam int NAW = 25;
    localparam int NCW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [24:0] in_product = '0;

    always #5 clk = ~clk;

    product_accumulator_if #(.ACC_W(AW),  .CNT_W(CW))  bus_a ();
    product_accumulator_if #(.ACC_W(NAW), .CNT_W(NCW)) bus_b ();

    assign bus_a.in_valid   = in_valid;
    assign bus_a.in_product = in_product;
    assign bus_a.in_last    = in_last;
    assign bus_a.out_ready  = out_ready;
    assign bus_b.in_valid   = in_valid;
    assign bus_b.in_product = in_product;
    assign bus_b.in_last    = in_last;
    assign bus_b.out_ready  = out_ready;

    product_accumulator #(.ACC_W(AW), .CNT_W(CW)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    product_accumulator #(.ACC_W(NAW), .CNT_W(NCW)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    typedef struct {
        logic [63:0] sa; logic [63:0] ca; logic oa;
        logic [63:0] sb; logic [63:0] cb; logic ob;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    longint unsigned frame_total = 0;
    int          frame_n = 0;
    logic        rand_ready = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endfunction

    // frame result from the plain arithmetic total of all accepted products
    function automatic exp_t model(longint unsigned tot, int n);
        exp_t e;
        longint unsigned max_a = (64'd1 << AW) - 1;
        longint unsigned max_b = (64'd1 << NAW) - 1;
        int cap_a = (1 << CW) - 1;
        int cap_b = (1 << NCW) - 1;
        e.oa = (tot > max_a);
        e.ob = (tot > max_b);
`ifdef ACC_SAT_EN
        e.sa = e.oa ? max_a : tot;
        e.sb = e.ob ? max_b : tot;
`else
        e.sa = tot & max_a;
        e.sb = tot & max_b;
`endif
        e.ca = 64'(n > cap_a ? cap_a : n);
        e.cb = 64'(n > cap_b ? cap_b : n);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [24:0] p, input logic l);
        int waited = 0;
        in_valid = 1'b1;
        in_product = p;
        in_last = l;
        while (!bus_a.in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!bus_a.in_ready) begin
            chk("in_ready_timeout", 64'(bus_a.in_ready), 64'd1);
        end else begin
            frame_total += longint'(p);
            frame_n++;
            if (l) begin
                exp_q.push_back(model(frame_total, frame_n));
                frame_total = 0;
                frame_n = 0;
            end
            tick();
        end
        in_valid = 1'b0;
        in_product = 25'($urandom);
        in_last = 1'($urandom_range(0, 1));
    endtask

    // monitor: every cycle a result is presented it must equal the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
            end else if (bus_a.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q[0];
                    chk("sum_a",   64'(bus_a.out_sum),   e.sa);
                    chk("count_a", 64'(bus_a.out_count), e.ca);
                    chk("ovf_a",   64'(bus_a.out_ovf),   64'(e.oa));
                    chk("valid_b", 64'(bus_b.out_valid), 64'd1);
                    chk("sum_b",   64'(bus_b.out_sum),   e.sb);
                    chk("count_b", 64'(bus_b.out_count), e.cb);
                    chk("ovf_b",   64'(bus_b.out_ovf),   64'(e.ob));
                    chk("in_ready_in_done", 64'(bus_a.in_ready), 64'd0);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d want %0d", 1, 0);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [24:0] p;
        int waited;

        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready",  64'(bus_a.in_ready),  64'd0);
        chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_out_sum",   64'(bus_a.out_sum),   64'd0);
        chk("rst_out_count", 64'(bus_a.out_count), 64'd0);
        chk("rst_out_ovf",   64'(bus_a.out_ovf),   64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_first_edge", 64'(bus_a.in_ready), 64'd0);
        tick();
        chk("ready_after_first_edge", 64'(bus_a.in_ready), 64'd1);

        out_ready = 1'b1;
        send(25'd100, 1'b0);
        send(25'd200, 1'b0);
        send(25'd300, 1'b1);
        chk("latency_out_valid", 64'(bus_a.out_valid), 64'd1);
        chk("latency_in_ready",  64'(bus_a.in_ready),  64'd0);
        tick();
        chk("turnaround_in_ready",  64'(bus_a.in_ready),  64'd1);
        chk("turnaround_out_valid", 64'(bus_a.out_valid), 64'd0);

        send(25'd33423360, 1'b1);
        tick();

        out_ready = 1'b0;
        send(25'd5, 1'b0);
        send(25'd6, 1'b1);
        in_valid = 1'b1;
        in_product = 25'd77;
        in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_in_ready",  64'(bus_a.in_ready),  64'd0);
            chk("stall_out_valid", 64'(bus_a.out_valid), 64'd1);
        end
        out_ready = 1'b1;
        send(25'd77, 1'b1);
        tick();

        send(25'h1FF_FFFF, 1'b0);
        send(25'd1, 1'b1);
        tick();

        for (int i = 0; i < 5; i++) send(25'd1, i == 4);
        tick();

        send(25'd9, 1'b0);
        send(25'd10, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        frame_total = 0;
        frame_n = 0;
        chk("midframe_rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        send(25'd7, 1'b0);
        send(25'd8, 1'b1);
        tick();

        out_ready = 1'b0;
        send(25'd3, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        chk("done_rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        tick();

        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, 6);
            for (int b = 0; b < n; b++) begin
                if ($urandom_range(0, 2) == 0) p = 25'($urandom);
                else p = 25'($urandom_range(0, 1000));
                send(p, b == n - 1);
                if ($urandom_range(0, 3) == 0) tick();
            end
        end

        rand_ready = 1'b0;
        out_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            tick();
            waited++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
